// File: rtl/muldiv_unit_if.sv
// Request/result bundle for muldiv_unit: operation request in, HI/LO results and status out.
interface muldiv_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MIPS-style multiply/divide unit with HI/LO registers, one operand bit per cycle.
// Define MULDIV_SIGNED_EN for two's-complement MULT/DIV; otherwise they behave as MULTU/DIVU.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic         clock,
    input  logic         reset_n,
    muldiv_unit_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_t;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101,
        OP_NOP6  = 3'b110,
        OP_NOP7  = 3'b111
    } op_t;

    state_t             state, state_nx;
    logic [CW-1:0]      count;
    logic               is_div;
    logic [WIDTH-1:0]   a_raw;
    logic [WIDTH-1:0]   operand_b;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               done_q;
    logic               dbz_q;

    logic               accept;
    logic               move_hi;
    logic               move_lo;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_trial;
    logic [WIDTH-1:0]   step_hi;
    logic [WIDTH-1:0]   step_lo;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic               b_zero;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;
`ifdef MULDIV_SIGNED_EN
    logic               sign_a;
    logic               sign_b;
    logic               neg_res;
    logic               neg_rem;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        move_hi  = 1'b0;
        move_lo  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            accept   = 1'b1;
                            state_nx = RUN;
                        end
                        OP_MTHI: move_hi = 1'b1;
                        OP_MTLO: move_lo = 1'b1;
                        default: ;
                    endcase
                end
            end
            RUN:     if (count == CW'(1)) state_nx = FINISH;
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operands are reduced to magnitudes up front so the iterative core is always unsigned.
    always_comb begin
`ifdef MULDIV_SIGNED_EN
        sign_a = ((bus.op == OP_MULT) || (bus.op == OP_DIV)) && bus.a[WIDTH-1];
        sign_b = ((bus.op == OP_MULT) || (bus.op == OP_DIV)) && bus.b[WIDTH-1];
        a_mag  = sign_a ? -bus.a : bus.a;
        b_mag  = sign_b ? -bus.b : bus.b;
`else
        a_mag  = bus.a;
        b_mag  = bus.b;
`endif
    end

    // Multiply: {acc_hi,acc_lo} shifts right with conditional add. Divide: restoring step on {acc_hi,acc_lo}.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand_b} : '0);
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_trial = div_shift - {1'b0, operand_b};
        if (is_div) begin
            step_hi = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], ~div_trial[WIDTH]};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    always_comb begin
        b_zero = (operand_b == '0);
        prod   = {acc_hi, acc_lo};
        quo    = acc_lo;
        rem    = acc_hi;
`ifdef MULDIV_SIGNED_EN
        if (neg_res) begin
            prod = -prod;
            quo  = -acc_lo;
        end
        if (neg_rem) begin
            rem = -acc_hi;
        end
`endif
        if (is_div) begin
            if (b_zero) begin
                res_hi = a_raw;
                res_lo = '1;
            end else begin
                res_hi = rem;
                res_lo = quo;
            end
        end else begin
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count     <= '0;
            is_div    <= 1'b0;
            a_raw     <= '0;
            operand_b <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            neg_res   <= 1'b0;
            neg_rem   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                count     <= CW'(WIDTH);
                is_div    <= bus.op[1];
                a_raw     <= bus.a;
                operand_b <= b_mag;
                acc_hi    <= '0;
                acc_lo    <= a_mag;
`ifdef MULDIV_SIGNED_EN
                neg_res   <= sign_a ^ sign_b;
                neg_rem   <= sign_a;
`endif
            end
            if (move_hi) hi_q <= bus.a;
            if (move_lo) lo_q <= bus.a;
            if (state == RUN) begin
                acc_hi <= step_hi;
                acc_lo <= step_lo;
                count  <= count - CW'(1);
            end
            if (state == FINISH) begin
                hi_q   <= res_hi;
                lo_q   <= res_lo;
                done_q <= 1'b1;
                dbz_q  <= is_div & b_zero;
            end
        end
    end

    assign bus.busy        = (state != IDLE);
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at WIDTH=32; expectations follow MULDIV_SIGNED_EN.
module tb_muldiv_unit;
    localparam int WIDTH = 32;
    localparam int LIMIT = 100;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_NOP   = 3'b110;

`ifdef MULDIV_SIGNED_EN
    localparam logic [31:0] MULT1_HI = 32'hFFFF_FFFF;
    localparam logic [31:0] MULT2_HI = 32'h0000_0000;
    localparam logic [31:0] DIV1_LO  = 32'hFFFF_FFFD;
    localparam logic [31:0] DIV1_HI  = 32'hFFFF_FFFF;
    localparam logic [31:0] DIV2_LO  = 32'hFFFF_FFFD;
    localparam logic [31:0] DIV2_HI  = 32'h0000_0001;
    localparam logic [31:0] DIV3_LO  = 32'h8000_0000;
    localparam logic [31:0] DIV3_HI  = 32'h0000_0000;
`else
    localparam logic [31:0] MULT1_HI = 32'h0000_0006;
    localparam logic [31:0] MULT2_HI = 32'hFFFF_FFFB;
    localparam logic [31:0] DIV1_LO  = 32'h7FFF_FFFC;
    localparam logic [31:0] DIV1_HI  = 32'h0000_0001;
    localparam logic [31:0] DIV2_LO  = 32'h0000_0000;
    localparam logic [31:0] DIV2_HI  = 32'h0000_0007;
    localparam logic [31:0] DIV3_LO  = 32'h0000_0000;
    localparam logic [31:0] DIV3_HI  = 32'h8000_0000;
`endif

    logic clock = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_fail = 0;

    muldiv_unit_if #(.WIDTH(WIDTH)) bus ();

    muldiv_unit #(.WIDTH(WIDTH)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic begin_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input logic [31:0] old_hi, input logic [31:0] old_lo,
                             output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        while (!bus.done && lat < LIMIT) begin
            if (bus.busy) bcnt++;
            if (lat == WIDTH) begin
                check({tag, "_hold_hi"}, bus.hi, old_hi);
                check({tag, "_hold_lo"}, bus.lo, old_lo);
            end
            @(posedge clock);
            #1;
            lat++;
        end
        check({tag, "_done_seen"}, 32'(bus.done), 32'd1);
    endtask

    task automatic after_done(input string tag);
        @(posedge clock);
        #1;
        check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
        check({tag, "_idle"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input logic exp_dbz);
        int lat;
        int bcnt;
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        old_hi = bus.hi;
        old_lo = bus.lo;
        begin_op(op, a, b);
        wait_done(tag, old_hi, old_lo, lat, bcnt);
        check({tag, "_lat"}, 32'(lat), 32'(WIDTH + 1));
        check({tag, "_busy_cycles"}, 32'(bcnt), 32'(WIDTH + 1));
        check({tag, "_hi"}, bus.hi, exp_hi);
        check({tag, "_lo"}, bus.lo, exp_lo);
        check({tag, "_dbz"}, 32'(bus.div_by_zero), 32'(exp_dbz));
        after_done(tag);
    endtask

    initial begin
        int lat;
        int bcnt;
        int seen;

        reset_n   = 1'b0;
        bus.start = 1'b0;
        bus.op    = '0;
        bus.a     = '0;
        bus.b     = '0;
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_dbz", 32'(bus.div_by_zero), 32'd0);
        check("rst_hi", bus.hi, 32'd0);
        check("rst_lo", bus.lo, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_op("mult_m3x7", OP_MULT, 32'hFFFF_FFFD, 32'h0000_0007, MULT1_HI, 32'hFFFF_FFEB, 1'b0);
        run_op("mult_m2xm3", OP_MULT, 32'hFFFF_FFFE, 32'hFFFF_FFFD, MULT2_HI, 32'h0000_0006, 1'b0);
        run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E, 1'b0);
        run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, DIV1_HI, DIV1_LO, 1'b0);
        run_op("div_7_m2", OP_DIV, 32'h0000_0007, 32'hFFFF_FFFE, DIV2_HI, DIV2_LO, 1'b0);
        run_op("div_minneg", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, DIV3_HI, DIV3_LO, 1'b0);
        run_op("div_5_0", OP_DIV, 32'd5, 32'd0, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1);
        run_op("divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'h0000_0000, 32'h0000_0003, 1'b0);
        run_op("divu_7_0", OP_DIVU, 32'd7, 32'd0, 32'h0000_0007, 32'hFFFF_FFFF, 1'b1);

        // Second request lands at cycle 5 of a running MULTU and must be dropped.
        begin_op(OP_MULTU, 32'd2, 32'd3);
        repeat (4) begin
            @(posedge clock);
            #1;
        end
        begin_op(OP_DIVU, 32'd100, 32'd7);
        wait_done("ignore", 32'd0, 32'd0, lat, bcnt);
        check("ignore_lat", 32'(lat), 32'(WIDTH + 1 - 5));
        check("ignore_hi", bus.hi, 32'd0);
        check("ignore_lo", bus.lo, 32'd6);
        check("ignore_dbz", 32'(bus.div_by_zero), 32'd0);
        after_done("ignore");

        run_op("divu_11_0", OP_DIVU, 32'd11, 32'd0, 32'h0000_000B, 32'hFFFF_FFFF, 1'b1);

        begin_op(OP_MULTU, 32'd5, 32'd5);
        repeat (9) begin
            @(posedge clock);
            #1;
        end
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        check("midrst_dbz", 32'(bus.div_by_zero), 32'd0);
        check("midrst_hi", bus.hi, 32'd0);
        check("midrst_lo", bus.lo, 32'd0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (bus.done || bus.busy) seen++;
        end
        check("midrst_quiet", 32'(seen), 32'd0);
        check("midrst_lo_after", bus.lo, 32'd0);
        run_op("post_rst_divu", OP_DIVU, 32'd9, 32'd3, 32'h0000_0000, 32'h0000_0003, 1'b0);

        begin_op(OP_MTHI, 32'h1234_5678, 32'd0);
        check("mthi_hi", bus.hi, 32'h1234_5678);
        check("mthi_busy", 32'(bus.busy), 32'd0);
        check("mthi_done", 32'(bus.done), 32'd0);
        begin_op(OP_MTLO, 32'h9ABC_DEF0, 32'd0);
        check("mtlo_lo", bus.lo, 32'h9ABC_DEF0);
        check("mtlo_hi", bus.hi, 32'h1234_5678);
        check("mtlo_busy", 32'(bus.busy), 32'd0);
        check("mtlo_done", 32'(bus.done), 32'd0);
        @(posedge clock);
        #1;
        check("mtlo_later_busy", 32'(bus.busy), 32'd0);
        check("mtlo_later_done", 32'(bus.done), 32'd0);

        begin_op(OP_NOP, 32'hDEAD_BEEF, 32'd1);
        check("nop_busy", 32'(bus.busy), 32'd0);
        check("nop_hi", bus.hi, 32'h1234_5678);
        check("nop_lo", bus.lo, 32'h9ABC_DEF0);
        @(posedge clock);
        #1;
        check("nop_done", 32'(bus.done), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
